io_pad_arbiter: RTL

- Shares the 38 user IO pads between NUM_DESIGNS user designs, e.g. the AS2650 core plus future cores.
- Sits between the user-area pads and the design instances inside the wrapper.
- A Wishbone slave register selects the pad owner.
- Every owner change runs a sequence: all pads tristated, all designs held in reset for GUARD_CYCLES, then the new owner is released.

---
 rtl/io_pad_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: shares the 38 user IO pads between NUM_DESIGNS designs, with a guarded owner switch.
// Optional sticky CTRL lock is compiled in when IO_PAD_ARBITER_LOCK_EN is defined.
module io_pad_arbiter #(
   parameter int unsigned NUM_DESIGNS  = 4,
   parameter int unsigned SEL_W        = 2,
   parameter int unsigned GUARD_CYCLES = 16,
   parameter int unsigned RESET_SEL    = 0,
   parameter logic [31:0] BASE_ADR     = 32'h3000_0000
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_ni,
   input  logic                        wbs_cyc_i,
   input  logic                        wbs_stb_i,
   input  logic                        wbs_we_i,
   input  logic [31:0]                 wbs_adr_i,
   input  logic [31:0]                 wbs_dat_i,
   input  logic [3:0]                  wbs_sel_i,
   output logic                        wbs_ack_o,
   output logic [31:0]                 wbs_dat_o,
   input  logic [37:0]                 io_in,
   output logic [37:0]                 io_out,
   output logic [37:0]                 io_oeb,
   input  logic [NUM_DESIGNS*38-1:0]   dsn_io_out,
   input  logic [NUM_DESIGNS*38-1:0]   dsn_io_oeb,
   output logic [NUM_DESIGNS*38-1:0]   dsn_io_in,
   output logic [NUM_DESIGNS-1:0]      dsn_rst_n,
   output logic                        busy_o
);
   localparam int unsigned PADS  = 38;
   localparam int unsigned CNT_W = $clog2(GUARD_CYCLES);

   localparam logic [0:0] ISOLATE = 1'b0;
   localparam logic [0:0] ACTIVE  = 1'b1;

   logic [0:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [SEL_W-1:0] cur_sel, cur_sel_n;
   logic [SEL_W-1:0] pend_sel, pend_sel_n;
   logic             lock, lock_n;
   logic             req, acc, wr_ctrl, sel_ok, lock_set;
   logic [31:0]      rdata;
   logic             unused_bits;

   // A request is taken only when no ack is outstanding, so a held request is acked every other cycle
   assign req     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign acc     = req & ~wbs_ack_o;
   assign wr_ctrl = acc & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
   assign sel_ok  = wbs_sel_i[0] & (wbs_dat_i[7:0] < 8'(NUM_DESIGNS))
                  & (wbs_dat_i[SEL_W-1:0] != cur_sel) & ~lock;

`ifdef IO_PAD_ARBITER_LOCK_EN
   assign lock_set = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[8];
`else
   assign lock_set = 1'b0;
`endif

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:8], wbs_sel_i[3:1]};

   // State register
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= ISOLATE;
         cnt      <= CNT_W'(GUARD_CYCLES - 1);
         cur_sel  <= SEL_W'(RESET_SEL);
         pend_sel <= SEL_W'(RESET_SEL);
         lock     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         cur_sel  <= cur_sel_n;
         pend_sel <= pend_sel_n;
         lock     <= lock_n;
      end
   end

   // Next state: count down the guard interval, or start a switch on an accepted CTRL write
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      cur_sel_n  = cur_sel;
      pend_sel_n = pend_sel;
      lock_n     = lock | lock_set;
      case (state)
         ISOLATE: begin
            if (cnt == '0) begin
               cur_sel_n = pend_sel;
               state_n   = ACTIVE;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            if (wr_ctrl && sel_ok) begin
               pend_sel_n = wbs_dat_i[SEL_W-1:0];
               cnt_n      = CNT_W'(GUARD_CYCLES - 1);
               state_n    = ISOLATE;
            end
         end
      endcase
   end

   // Register read mux
   always_comb begin
      rdata = '0;
      case (wbs_adr_i[3:2])
         2'd0: begin
            rdata[SEL_W-1:0] = pend_sel;
            rdata[8]         = lock;
         end
         2'd1: begin
            rdata[SEL_W-1:0] = cur_sel;
            rdata[16]        = (state == ISOLATE);
         end
         default: rdata = '0;
      endcase
   end

   // Wishbone ack and read data
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= acc;
         wbs_dat_o <= acc ? rdata : '0;
      end
   end

   // Pad routing: everything isolated unless ACTIVE, then only the owner's slice is connected
   always_comb begin
      io_out    = '0;
      io_oeb    = '1;
      dsn_io_in = '0;
      dsn_rst_n = '0;
      if (state == ACTIVE) begin
         for (int unsigned k = 0; k < NUM_DESIGNS; k++) begin
            if (cur_sel == SEL_W'(k)) begin
               io_out                   = dsn_io_out[k*PADS +: PADS];
               io_oeb                   = dsn_io_oeb[k*PADS +: PADS];
               dsn_io_in[k*PADS +: PADS] = io_in;
               dsn_rst_n[k]             = 1'b1;
            end
         end
      end
   end

   assign busy_o = (state == ISOLATE);

endmodule
